// File: rtl/tt_adder_pkg.sv
// Shared encodings for the byte-serial wide adder tile: commands, modes,
// FSM states and uio bit positions.
package tt_adder_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD_A = 2'b00,
        CMD_LOAD_B = 2'b01,
        CMD_EXEC   = 2'b10,
        CMD_READ   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // uio_in fields
    localparam int UIO_STRB    = 0;
    localparam int UIO_CMD_LO  = 1;
    localparam int UIO_CMD_HI  = 2;
    localparam int UIO_MODE_LO = 3;
    localparam int UIO_MODE_HI = 4;

    // uio_out fields
    localparam int UIO_DONE  = 4;
    localparam int UIO_OVF   = 5;
    localparam int UIO_CARRY = 6;
    localparam int UIO_BUSY  = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/byte_add_slice.sv
// One byte of the carry chain: 8-bit add with carry-in, carry-out and
// signed overflow of bit 7. Shared across all byte positions.
module byte_add_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       ovf
);

    logic [8:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    assign sum  = full[7:0];
    assign cout = full[8];
    assign ovf  = (a[7] == b[7]) && (sum[7] != a[7]);

endmodule

// File: rtl/tt_um_adder_wide.sv
// Byte-serial add/sub/accumulate tile: operands loaded byte by byte over
// ui_in, computed LSB first one byte per clock, result read over uo_out.
module tt_um_adder_wide
    import tt_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NBYTES = WIDTH / 8;
    localparam int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [PW-1:0] LAST = PW'(NBYTES - 1);

    state_e state_q, state_d;
    mode_e  mode_q;
    cmd_e   cmd;

    logic [NBYTES-1:0][7:0] a_q, b_q, r_q;
    logic [PW-1:0] a_ptr, b_ptr, rd_ptr, cnt;
    logic carry_q, cflag_q, ovf_q, strb_q;
    logic strobe_evt;

    logic [7:0] op_a, op_b, sum;
    logic       cout, slice_ovf;

    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:5]};

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign cmd = cmd_e'(uio_in[UIO_CMD_HI:UIO_CMD_LO]);
    // Strobes are only honoured in IDLE; anything arriving while busy is dropped.
    assign strobe_evt = ena && uio_in[UIO_STRB] && !strb_q && (state_q == S_IDLE);

    always_comb begin
        op_a = a_q[cnt];
        op_b = b_q[cnt];
        case (mode_q)
            MODE_SUB: op_b = ~b_q[cnt];
            MODE_ACC: begin
                op_a = r_q[cnt];
                op_b = a_q[cnt];
            end
            default: ;
        endcase
    end

    byte_add_slice u_slice (
        .a    (op_a),
        .b    (op_b),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout),
        .ovf  (slice_ovf)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (strobe_evt && cmd == CMD_EXEC) state_d = S_EXEC;
            S_EXEC:  if (cnt == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_ADD;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            a_ptr   <= '0;
            b_ptr   <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cflag_q <= 1'b0;
            ovf_q   <= 1'b0;
            strb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            strb_q  <= uio_in[UIO_STRB];

            if (strobe_evt) begin
                case (cmd)
                    CMD_LOAD_A: begin
                        a_q[a_ptr] <= ui_in;
                        a_ptr      <= bump(a_ptr);
                    end
                    CMD_LOAD_B: begin
                        b_q[b_ptr] <= ui_in;
                        b_ptr      <= bump(b_ptr);
                    end
                    CMD_EXEC: begin
                        mode_q  <= mode_e'(uio_in[UIO_MODE_HI:UIO_MODE_LO]);
                        cnt     <= '0;
                        carry_q <= (uio_in[UIO_MODE_HI:UIO_MODE_LO] == MODE_SUB);
                    end
                    default: rd_ptr <= bump(rd_ptr);
                endcase
            end

            if (state_q == S_EXEC) begin
                r_q[cnt] <= (mode_q == MODE_CLR) ? '0 : sum;
                carry_q  <= cout;
                cnt      <= cnt + 1'b1;
                if (cnt == LAST) begin
                    cflag_q <= (mode_q == MODE_CLR) ? 1'b0 :
                               (mode_q == MODE_SUB) ? !cout : cout;
                    ovf_q   <= (mode_q == MODE_CLR) ? 1'b0 : slice_ovf;
                end
            end

            if (state_q == S_DONE) begin
                a_ptr  <= '0;
                b_ptr  <= '0;
                rd_ptr <= '0;
            end
        end
    end

    assign uo_out = r_q[rd_ptr];
    assign uio_oe = UIO_OE_MASK;

    always_comb begin
        uio_out            = '0;
        uio_out[UIO_BUSY]  = (state_q == S_EXEC);
        uio_out[UIO_CARRY] = cflag_q;
        uio_out[UIO_OVF]   = ovf_q;
        uio_out[UIO_DONE]  = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_tt_um_adder_wide.sv
// Scoreboard bench for tt_um_adder_wide: directed vectors plus random
// transactions against an arithmetic reference model.
module tb_tt_um_adder_wide;
    import tt_adder_pkg::*;

    localparam int WIDTH  = 16;
    localparam int NBYTES = WIDTH / 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_adder_wide #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             o;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] rd_q[$];

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [WIDTH-1:0] a_m = '0, b_m = '0, r_m = '0;
    int a_p = 0, b_p = 0, rd_p = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic strobe(input logic [1:0] cmd, input logic [1:0] mode, input logic [7:0] data);
        @(negedge clk);
        ui_in  = data;
        uio_in = {3'b000, mode, cmd, 1'b1};
        @(negedge clk);
        uio_in[0] = 1'b0;
        @(posedge clk);
    endtask

    task automatic model_reset();
        a_m = '0; b_m = '0; r_m = '0;
        a_p = 0; b_p = 0; rd_p = 0;
    endtask

    task automatic load(input bit is_b, input logic [WIDTH-1:0] v);
        for (int i = 0; i < NBYTES; i++) begin
            logic [7:0] d;
            d = v[i*8 +: 8];
            strobe(is_b ? CMD_LOAD_B : CMD_LOAD_A, 2'b00, d);
            if (is_b) begin
                b_m[b_p*8 +: 8] = d;
                b_p = (b_p + 1) % NBYTES;
            end else begin
                a_m[a_p*8 +: 8] = d;
                a_p = (a_p + 1) % NBYTES;
            end
        end
    endtask

    task automatic load_byte_a(input logic [7:0] d);
        strobe(CMD_LOAD_A, 2'b00, d);
        a_m[a_p*8 +: 8] = d;
        a_p = (a_p + 1) % NBYTES;
    endtask

    // poke=1 issues a LOAD_A strobe mid-computation, which must be ignored
    task automatic exec(input logic [1:0] mode, input bit poke);
        exp_t e;
        longint unsigned full;
        logic [WIDTH-1:0] r;
        case (mode)
            2'd0: begin
                full = longint'(a_m) + longint'(b_m);
                r = full[WIDTH-1:0];
                e.c = full[WIDTH];
                e.o = (a_m[WIDTH-1] == b_m[WIDTH-1]) && (r[WIDTH-1] != a_m[WIDTH-1]);
            end
            2'd1: begin
                r = a_m - b_m;
                e.c = (a_m < b_m);
                e.o = (a_m[WIDTH-1] != b_m[WIDTH-1]) && (r[WIDTH-1] != a_m[WIDTH-1]);
            end
            2'd2: begin
                full = longint'(r_m) + longint'(a_m);
                r = full[WIDTH-1:0];
                e.c = full[WIDTH];
                e.o = (r_m[WIDTH-1] == a_m[WIDTH-1]) && (r[WIDTH-1] != r_m[WIDTH-1]);
            end
            default: begin
                r = '0;
                e.c = 1'b0;
                e.o = 1'b0;
            end
        endcase
        e.r = r;
        r_m = r;
        sb_q.push_back(e);
        strobe(CMD_EXEC, mode, 8'h00);
        if (poke) begin
            @(negedge clk);
            ui_in  = 8'h55;
            uio_in = {3'b000, 2'b00, CMD_LOAD_A, 1'b1};
            @(negedge clk);
            uio_in[0] = 1'b0;
        end
        repeat (NBYTES + 3) @(posedge clk);
        a_p = 0; b_p = 0; rd_p = 0;
    endtask

    task automatic read_all();
        for (int i = 0; i < NBYTES; i++) begin
            strobe(CMD_READ, 2'b00, 8'h00);
            rd_p = (rd_p + 1) % NBYTES;
            rd_q.push_back(r_m[rd_p*8 +: 8]);
        end
        @(posedge clk);
    endtask

    // monitor: done pulses pop the scoreboard; read-backs pop rd_q
    int         busy_cnt = 0;
    bit         chk0 = 1'b0;
    logic [7:0] b0 = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                chk0 = 1'b0;
            end else begin
                if (chk0) begin
                    chk("byte0_after_done", {24'b0, uo_out}, {24'b0, b0});
                    chk("done_one_cycle", {30'b0, uio_out[7], uio_out[4]}, 32'd0);
                    chk0 = 1'b0;
                end
                if (rd_q.size() > 0)
                    chk("read_byte", {24'b0, uo_out}, {24'b0, rd_q.pop_front()});
                if (uio_out[7]) busy_cnt++;
                if (uio_out[4]) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("busy_len", busy_cnt, NBYTES);
                        chk("carry_flag", {31'b0, uio_out[6]}, {31'b0, e.c});
                        chk("ovf_flag", {31'b0, uio_out[5]}, {31'b0, e.o});
                        b0 = e.r[7:0];
                        chk0 = 1'b1;
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_uo_out", {24'b0, uo_out}, 32'd0);
        chk("reset_uio_out", {24'b0, uio_out}, 32'd0);
        chk("reset_uio_oe", {24'b0, uio_oe}, 32'h0F0);
        rst_n = 1'b1;

        load(0, 16'h1234); load(1, 16'h0FCD); exec(MODE_ADD, 0); read_all();
        load(0, 16'hFFFF); load(1, 16'h0001); exec(MODE_ADD, 0); read_all();
        load(0, 16'h7FFF); load(1, 16'h0001); exec(MODE_ADD, 0); read_all();
        load(0, 16'h0005); load(1, 16'h0007); exec(MODE_SUB, 0); read_all();
        load(0, 16'h0007); load(1, 16'h0005); exec(MODE_SUB, 0); read_all();

        exec(MODE_CLR, 0);
        load(0, 16'h0100);
        exec(MODE_ACC, 0);
        exec(MODE_ACC, 1);
        exec(MODE_ACC, 1);
        read_all();

        // pointer wrap: third byte lands on byte 0
        load_byte_a(8'hAA); load_byte_a(8'hBB); load_byte_a(8'hCC);
        load(1, 16'h0000);
        ena = 1'b0;
        strobe(CMD_LOAD_A, 2'b00, 8'h77);
        ena = 1'b1;
        exec(MODE_ADD, 0); read_all();

        // reset one cycle into EXEC
        load(0, 16'h4321); load(1, 16'h1111);
        @(negedge clk);
        uio_in = {3'b000, MODE_ADD, CMD_EXEC, 1'b1};
        @(negedge clk);
        uio_in[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_exec_busy", {31'b0, uio_out[7]}, 32'd0);
        chk("rst_exec_uo_out", {24'b0, uo_out}, 32'd0);
        chk("rst_exec_uio_out", {24'b0, uio_out}, 32'd0);
        chk("rst_exec_uio_oe", {24'b0, uio_oe}, 32'h0F0);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);

        for (int n = 0; n < 24; n++) begin
            load(0, WIDTH'($urandom));
            load(1, WIDTH'($urandom));
            exec(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            read_all();
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("reads_drained", rd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_adder_wide.md
Name: tt_um_adder_wide

Overview:
- Parametrised successor to the 8-bit combinational adder tile.
- Adds, subtracts or accumulates WIDTH-bit operands that are loaded byte by byte over ui_in.
- Computes byte-serially, one byte per clock, LSB first, with a registered carry chain.
- Result bytes are read back over uo_out.
- Sits as a TinyTapeout user tile behind the standard tt_um port set.

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 8, legal range 8..32.
- NBYTES (localparam), WIDTH/8, bytes per operand.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous to clk and active-low (one clock domain, synchronous active-low reset).
- ena  in  1  tile enable; when 0, all strobes are ignored and state holds.
- ui_in  in  8  data byte for operand loads.
- uio_in  in  8  [0] strobe, [2:1] cmd, [4:3] mode; [7:5] unused.
- uo_out  out  8  result byte at read pointer.
- uio_out  out  8  [7] busy, [6] carry/borrow, [5] signed overflow, [4] done; [3:0] = 0.
- uio_oe  out  8  constant 8'hF0.

Behaviour:
- Strobe event: at a clock edge where ena=1, uio_in[0]=1 and strb_q=0. strb_q is a registered copy of uio_in[0], cleared by reset. One event per rising strobe.
- cmd 00 LOAD_A: A byte[a_ptr] <= ui_in; a_ptr++ mod NBYTES.
- cmd 01 LOAD_B: same for B with b_ptr.
- cmd 10 EXEC: latch mode, go to EXEC.
- cmd 11 READ: rd_ptr++ mod NBYTES.
- Modes:
  - 00 ADD: R = A+B.
  - 01 SUB: R = A-B, computed as A + ~B + 1.
  - 10 ACC: R = R+A.
  - 11 CLR: R = 0, flags 0.
- FSM states:
  - IDLE: accepts all cmds.
  - EXEC: cnt = 0..NBYTES-1. Each cycle computes one byte, with carry held in a 1-bit register (seeded 1 for SUB, else 0). cnt==NBYTES-1 goes to DONE.
  - DONE: one cycle, done=1, then IDLE.
- Latency: EXEC event at edge N; busy=1 from N+1 through N+NBYTES; done=1 during cycle N+NBYTES+1; busy=0 then.
- Flags, updated in the final EXEC cycle:
  - carry = carry-out for ADD/ACC; borrow = ~carry-out for SUB (1 when A<B unsigned).
  - ovf = signed overflow of the MSB.
  - Flags hold until the next EXEC.
- Result register R updates byte-wise during EXEC. uo_out = R byte[rd_ptr], combinational from registers.
- EXEC completion (the DONE cycle) resets a_ptr, b_ptr and rd_ptr to 0. A and B retain their contents.
- Any strobe while busy is ignored; it is neither queued nor counted.
- Pointers wrap silently: an extra load overwrites byte 0.
- ena=0 mid-EXEC: the computation completes regardless; only new strobes are masked.
- Reset: all state 0, FSM=IDLE.
  - uo_out=0; uio_out=0; uio_oe=8'hF0 at all times.
  - Reset mid-EXEC aborts; R=0.
- Width rules: all arithmetic mod 2^WIDTH; per-byte sum is 9 bits (byte + byte + carry).

Decomposition:
- Package tt_adder_pkg:
  - cmd encodings CMD_LOAD_A/B, CMD_EXEC, CMD_READ;
  - mode encodings MODE_ADD/SUB/ACC/CLR;
  - FSM state enum S_IDLE/S_EXEC/S_DONE;
  - uio bit-index constants.
- One sub-module byte_add_slice: 8-bit a, b, cin -> sum, cout, ovf. Purely combinational, instantiated once and time-shared across bytes.
- Top holds the FSM, pointers, registers and edge detect.

Test Plan (WIDTH=16):
- Load A=0x1234, B=0x0FCD, EXEC ADD -> busy 2 cycles, done pulse. READ bytes 0x01 then 0x22 (R=0x2201), carry=0, ovf=0.
- A=0xFFFF, B=0x0001, ADD -> R=0x0000, carry=1, ovf=0. A=0x7FFF, B=0x0001, ADD -> R=0x8000, ovf=1.
- A=0x0005, B=0x0007, SUB -> R=0xFFFE, borrow=1. A=0x0007, B=0x0005 -> R=0x0002, borrow=0.
- CLR, then A=0x0100 and ACC three times -> R=0x0300. Strobes issued while busy leave R unchanged.
- Three LOAD_A strobes 0xAA, 0xBB, 0xCC -> A=0xBBCC (wrap). With ena=0 a strobe has no effect.
- Assert rst_n=0 one cycle into EXEC -> next cycle busy=0, R=0, uo_out=0, uio_out=0, uio_oe=0xF0.
